// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // funct3[1:0] encodes the access size for both loads and stores.
   function automatic logic access_err(input logic is_write, input logic [2:0] funct3,
                                       input logic [2:0] off);
      logic err;
      err = is_write ? funct3[2] : (funct3 == 3'b111);
      case (funct3[1:0])
         2'b01:   if (off[0] != 1'b0) err = 1'b1;
         2'b10:   if (off[1:0] != 2'b00) err = 1'b1;
         2'b11:   if (off != 3'b000) err = 1'b1;
         default: ;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load select/extend and sub-word store merge.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] line,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        funct3,
   input  logic [2:0]        off,
   output logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] st_line
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] size_mask;
   logic [DATA_W-1:0] ins_mask;
   logic              sign;

   always_comb begin
      shifted = line >> {off, 3'b000};
      case (funct3)
         F3_B, F3_BU: begin
            size_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
            sign      = shifted[7];
         end
         F3_H, F3_HU: begin
            size_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            sign      = shifted[15];
         end
         F3_W, F3_WU: begin
            size_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
            sign      = shifted[31];
         end
         default: begin
            size_mask = {DATA_W{1'b1}};
            sign      = shifted[DATA_W-1];
         end
      endcase
      // Unsigned variants have funct3[2] set; their sign bit is ignored.
      ld_data  = (shifted & size_mask) | ((sign && !funct3[2]) ? ~size_mask : '0);
      ins_mask = size_mask << {off, 3'b000};
      st_line  = (line & ~ins_mask) | ((wdata & size_mask) << {off, 3'b000});
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between EX and datamemory; one request in flight,
// sub-word stores done as read-modify-write.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request
// ST_RD   | MemRead asserted, memory line captured at end of cycle
// ST_WR   | MemWrite asserted with merged line for one cycle
// ST_RESP | response presented, held until rsp_ready
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   input  logic [DATA_W-1:0]     rd
);

   lsu_state_e              state_q, state_d;
   logic                    write_q, write_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [DM_ADDRESS+2:0]   addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [DATA_W-1:0]       line_q, line_d;
   logic                    err_q, err_d;
   logic [DATA_W-1:0]       ld_data;
   logic [DATA_W-1:0]       st_line;
   logic                    addr_unused;

   // Bytes above the memory depth alias onto the same lines.
   assign addr_unused = ^req_addr[DATA_W-1:DM_ADDRESS+3];

   assign req_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      line_d   = line_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr[DM_ADDRESS+2:0];
               wdata_d  = req_wdata;
               err_d    = access_err(req_write, req_funct3, req_addr[2:0]);
               if (err_d)
                  state_d = ST_RESP;
               else if (req_write && req_funct3 == F3_D)
                  state_d = ST_WR;
               else
                  state_d = ST_RD;
            end
         end
         ST_RD: begin
            line_d  = rd;
            state_d = write_q ? ST_WR : ST_RESP;
         end
         ST_WR:   state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         line_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         line_q   <= line_d;
         err_q    <= err_d;
      end
   end

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .line    (line_q),
      .wdata   (wdata_q),
      .funct3  (funct3_q),
      .off     (addr_q[2:0]),
      .ld_data (ld_data),
      .st_line (st_line)
   );

   // Memory-side and response outputs decode only from registered state.
   assign MemRead   = (state_q == ST_RD);
   assign MemWrite  = (state_q == ST_WR);
   assign a         = addr_q[DM_ADDRESS+2:3];
   assign wd        = (state_q == ST_WR) ? st_line : '0;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = (state_q == ST_RESP) && err_q;
   assign rsp_rdata = (state_q == ST_RESP && !err_q && !write_q) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random bench for load_store_unit against a byte-array model.
module tb_load_store_unit;

   localparam int DM_ADDRESS = 9;
   localparam int DATA_W     = 64;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [DATA_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  MemRead;
   logic                  MemWrite;
   logic [DM_ADDRESS-1:0] a;
   logic [DATA_W-1:0]     wd;
   logic [DATA_W-1:0]     rd;

   logic [63:0] dm [0:511] = '{default: 64'd0};
   logic [7:0]  ref_mem [0:4095];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rd = dm[a];
   always @(posedge clk) if (MemWrite) dm[a] <= wd;

   load_store_unit #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .a          (a),
      .wd         (wd),
      .rd         (rd)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int hold, input bit keep_valid,
                         output logic [63:0] obs_rdata, output int waits);
      int          sz, base, lat, nr, nw, exp_lat, exp_nr, exp_nw;
      logic        exp_err;
      logic [63:0] exp_rd, exp_line;
      sz       = 1 << f3[1:0];
      base     = int'(addr[11:0]);
      exp_err  = (wr ? f3[2] : (f3 == 3'b111)) || ((int'(addr[2:0]) % sz) != 0);
      exp_rd   = '0;
      exp_line = '0;
      if (!exp_err && !wr) begin
         for (int i = 0; i < sz; i++) exp_rd |= 64'(ref_mem[base+i]) << (8*i);
         if (!f3[2] && sz < 8 && exp_rd[8*sz-1]) exp_rd |= ~((64'd1 << (8*sz)) - 64'd1);
      end
      if (!exp_err && wr) begin
         for (int i = 0; i < sz; i++) ref_mem[base+i] = 8'(wdata >> (8*i));
         for (int i = 0; i < 8; i++) exp_line |= 64'(ref_mem[(base & ~7)+i]) << (8*i);
      end
      exp_lat = exp_err ? 1 : ((wr && sz < 8) ? 3 : 2);
      exp_nr  = (exp_err || (wr && sz == 8)) ? 0 : 1;
      exp_nw  = (!exp_err && wr) ? 1 : 0;

      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      waits = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && waits < 6) begin
         waits++;
         @(negedge clk);
      end
      check("req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      if (!keep_valid) req_valid = 1'b0;

      lat = 0; nr = 0; nw = 0;
      do begin
         @(negedge clk);
         lat++;
         check("strobe_excl", 64'(MemRead & MemWrite), 64'd0);
         if (MemRead === 1'b1) nr++;
         if (MemWrite === 1'b1) nw++;
         if (MemRead === 1'b1 || MemWrite === 1'b1) check("mem_a", 64'(a), 64'(addr[11:3]));
         if (MemWrite === 1'b1) check("mem_wd", wd, exp_line);
      end while (rsp_valid !== 1'b1 && lat < 8);
      check("latency", 64'(lat), 64'(exp_lat));
      check("n_read", 64'(nr), 64'(exp_nr));
      check("n_write", 64'(nw), 64'(exp_nw));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      check("rsp_rdata", rsp_rdata, exp_rd);
      obs_rdata = rsp_rdata;

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 64'(rsp_valid), 64'd1);
         check("hold_rdata", rsp_rdata, exp_rd);
         check("hold_err", 64'(rsp_err), 64'(exp_err));
         check("hold_strobes", 64'({MemRead, MemWrite}), 64'd0);
         check("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] obs, addr, wdata;
      logic [2:0]  f3, m;
      logic        wr;
      int          waits;

      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_memread", 64'(MemRead), 64'd0);
      check("rst_memwrite", 64'(MemWrite), 64'd0);
      check("rst_a", 64'(a), 64'd0);
      check("rst_wd", wd, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 32; i++)
         do_req(1'b1, 3'b011, 64'(i*8), {$urandom, $urandom}, 0, 1'b0, obs, waits);

      // LD of a known doubleword
      do_req(1'b1, 3'b011, 64'h10, 64'h8877665544332211, 0, 1'b0, obs, waits);
      do_req(1'b0, 3'b011, 64'h10, 64'h0, 0, 1'b0, obs, waits);
      check("ld_const", obs, 64'h8877665544332211);

      // LB / LBU of a negative byte
      do_req(1'b1, 3'b011, 64'h10, 64'h8011223344556677, 0, 1'b0, obs, waits);
      do_req(1'b0, 3'b000, 64'h17, 64'h0, 0, 1'b0, obs, waits);
      check("lb_const", obs, 64'hFFFFFFFFFFFFFF80);
      do_req(1'b0, 3'b100, 64'h17, 64'h0, 0, 1'b0, obs, waits);
      check("lbu_const", obs, 64'h0000000000000080);

      // SH into a zero line, then read the line back
      do_req(1'b1, 3'b011, 64'h08, 64'h0, 0, 1'b0, obs, waits);
      do_req(1'b1, 3'b001, 64'h0A, 64'hBEEF, 0, 1'b0, obs, waits);
      do_req(1'b0, 3'b011, 64'h08, 64'h0, 0, 1'b0, obs, waits);
      check("sh_readback", obs, 64'h00000000BEEF0000);

      // Misaligned and illegal requests
      do_req(1'b0, 3'b010, 64'h06, 64'h0, 0, 1'b0, obs, waits);
      do_req(1'b1, 3'b111, 64'h20, 64'h1234, 0, 1'b0, obs, waits);

      // Stalled response with EX holding a request
      do_req(1'b0, 3'b011, 64'h10, 64'h0, 5, 1'b1, obs, waits);
      do_req(1'b0, 3'b011, 64'h10, 64'h0, 0, 1'b0, obs, waits);
      check("next_accept_wait", 64'(waits), 64'd0);

      // Reset during the WR cycle of an SB
      req_write  = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 64'h31;
      req_wdata  = 64'h5A;
      req_valid  = 1'b1;
      @(negedge clk);
      check("sb_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("sb_rd_cycle", 64'(MemRead), 64'd1);
      @(negedge clk);
      check("sb_wr_cycle", 64'(MemWrite), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_memwrite", 64'(MemWrite), 64'd0);
      check("arst_memread", 64'(MemRead), 64'd0);
      check("arst_req_ready", 64'(req_ready), 64'd1);
      check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      do_req(1'b0, 3'b100, 64'h31, 64'h0, 0, 1'b0, obs, waits);

      for (int n = 0; n < 200; n++) begin
         wr    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         addr  = {$urandom, 20'($urandom), 12'($urandom_range(0, 255))};
         wdata = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) begin
            m = 3'((1 << f3[1:0]) - 1);
            addr[2:0] = addr[2:0] & ~m;
         end
         do_req(wr, f3, addr, wdata, $urandom_range(0, 2), 1'b0, obs, waits);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the EX stage and the `datamemory` array. It accepts one load or store per handshake and converts the ALU address and funct3 into doubleword-indexed `MemRead`/`MemWrite` strobes. Sub-word stores are done as read-modify-write; load data is sign- or zero-extended and returned to writeback on a valid/ready response channel.

## Interface
- `DM_ADDRESS`, 9: width of the doubleword index driven to memory.
- `DATA_W`, 64: data width; equals memory word width.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  EX stage presents a request.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV64 load/store funct3.
- `req_addr`  in  DATA_W  byte address (ALU result).
- `req_wdata`  in  DATA_W  store data, right-justified.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  writeback consumes the response.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores.
- `rsp_err`  out  1  misaligned or illegal funct3; no memory access was made.
- `MemRead`  out  1  to `datamemory`.
- `MemWrite`  out  1  to `datamemory`.
- `a`  out  DM_ADDRESS  doubleword index = `req_addr[DM_ADDRESS+2:3]`.
- `wd`  out  DATA_W  write data to memory.
- `rd`  in  DATA_W  read data from memory; combinational on `a`.

## Operation
- States: IDLE, RD, WR, RESP.
  - `req_ready` = (state == IDLE).
  - A request is accepted on `req_valid && req_ready`.
  - Accepting a request registers `req_write`, `req_funct3`, `req_addr`, and `req_wdata`.
- Decode of funct3 for loads:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: illegal.
- Decode of funct3 for stores:
  - 000 SB, 001 SH, 010 SW, 011 SD.
  - funct3[2] = 1: illegal.
- Misaligned accesses:
  - Half with `addr[0]` ≠ 0.
  - Word with `addr[1:0]` ≠ 0.
  - Double with `addr[2:0]` ≠ 0.
- Transitions from IDLE on accept:
  - Error (misaligned or illegal) → RESP with `rsp_err` = 1.
  - Load or sub-word store → RD.
  - SD → WR.
- RD:
  - Drives `MemRead` = 1 with `a` valid.
  - Captures `rd` into the line register at end of cycle.
  - Load → RESP; sub-word store → WR.
- WR:
  - Drives `MemWrite` = 1 and `wd` = merged line for exactly one cycle, then → RESP.
  - For SD the merged line is `req_wdata`.
  - For SB/SH/SW the merge replaces bytes `addr[2:0]` through `addr[2:0]+size-1` of the captured line with the low bytes of `req_wdata`. Other bytes keep their captured values.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` = selected bytes of the captured line (byte lane = `addr[2:0]`), extended to DATA_W.
  - `rsp_rdata` and `rsp_err` are held stable while `rsp_ready` = 0.
  - On `rsp_ready` → IDLE.
- Drive rules:
  - `MemRead` and `MemWrite` are never both 1.
  - Both are 0 in IDLE and RESP.
  - `a` and `wd` are stable for the whole cycle they qualify.
  - All memory-side outputs decode from registered state only, so no glitches reach the combinational memory.

## Timing
- Reset value of every output: `req_ready` = 1 (IDLE), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `MemRead` = 0, `MemWrite` = 0, `a` = 0, `wd` = 0.
- Latency from the accept edge to first `rsp_valid` cycle:
  - Load: 2 cycles.
  - SD: 2 cycles.
  - SB/SH/SW: 3 cycles.
  - Error: 1 cycle.
- Throughput: at most one request in flight. No new accept until the RESP handshake completes. The earliest next accept is the cycle after `rsp_valid && rsp_ready`.
- `rsp_ready` held 0: unit stays in RESP indefinitely, with no memory traffic.
- `req_valid` high while not ready: ignored; the request must be held by EX.
- Reset mid-operation:
  - Immediate return to IDLE; all strobes drop asynchronously.
  - An interrupted RMW may leave that line unmodified, but never partially merged.
  - No response is issued for the aborted request.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`);
  - a size/alignment-check function.
- Sub-module `lsu_align` is purely combinational: the load byte-select/extend plus the store byte merge. The FSM and registers stay in `load_store_unit`.

## Test plan
- LD at addr 0x10 with `mem[2]` = 0x8877665544332211 → `MemRead` one cycle with `a` = 2; `rsp_rdata` = 0x8877665544332211 two cycles after accept.
- LB at 0x17, then LBU at 0x17, with `mem[2]` = 0x80xx… → `rsp_rdata` = 0xFFFFFFFFFFFFFF80, then 0x0000000000000080.
- SH 0xBEEF at addr 0x0A over `mem[1]` = 0x0 → RD, then WR with `wd` = 0x00000000BEEF0000; a following LD at 0x08 returns the same value.
- LW at 0x06 and SD with funct3 = 111 → `rsp_err` = 1 one cycle after accept, with `MemRead` = `MemWrite` = 0 throughout.
- Load response with `rsp_ready` held 0 for 5 cycles, `req_valid` high throughout → `rsp_rdata` stable, `req_ready` = 0, no memory strobes. The next request is accepted the cycle after the handshake.
- `rst_n` pulsed low during WR of an SB → `MemWrite` drops immediately, state is IDLE, `req_ready` = 1, `rsp_valid` = 0.
